// File: rtl/irq_arbiter.sv
// Interrupt/exception arbiter feeding the CPU control decoder: latches peripheral
// request edges, masks them, picks one event by fixed priority and records cause/EPC.
module irq_arbiter #(
   parameter int NSRC = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [NSRC-1:0] irq_src,
   input  logic            mask_wr,
   input  logic [NSRC-1:0] mask_wdata,
   input  logic            pchigh,
   input  logic            exc_req,
   input  logic [31:0]     pc_in,
   input  logic            eret,
   output logic            irq_out,
   output logic            exc_out,
   output logic [2:0]      cause,
   output logic [31:0]     epc,
   output logic [NSRC-1:0] irq_mask,
   output logic            in_service,
   output logic            dbl_fault
);

   typedef enum logic [1:0] {IDLE, TAKE_EXC, TAKE_IRQ, SERVICE} state_e;

   state_e          state_q, state_d;
   logic [NSRC-1:0] prev_q, prev_d;
   logic [NSRC-1:0] pend_q, pend_d;
   logic [NSRC-1:0] mask_q, mask_d;
   logic [31:0]     epc_q, epc_d;
   logic [2:0]      cause_q, cause_d;
   logic            dbl_q, dbl_d;

   logic [NSRC-1:0] eligible, win_onehot;
   logic [2:0]      win_cause;
   logic            accept_exc, accept_irq;

   assign eligible = pend_q & mask_q;

   // Scan from the top down so the lowest eligible index is the last to overwrite.
   always_comb begin
      win_onehot = '0;
      win_cause  = '0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (eligible[i]) begin
            win_onehot    = '0;
            win_onehot[i] = 1'b1;
            win_cause     = 3'(i + 1);
         end
      end
   end

   // NOTE: every signal gets a default at the top so no path leaves it unassigned (no latch).
   always_comb begin
      state_d    = state_q;
      accept_exc = 1'b0;
      accept_irq = 1'b0;
      case (state_q)
         IDLE: begin
            if (!pchigh) begin
               if (exc_req) begin
                  accept_exc = 1'b1;
                  state_d    = TAKE_EXC;
               end else if (|eligible) begin
                  accept_irq = 1'b1;
                  state_d    = TAKE_IRQ;
               end
            end
         end
         TAKE_EXC, TAKE_IRQ: state_d = SERVICE;
         SERVICE:            if (eret) state_d = IDLE;
         default:            state_d = IDLE;
      endcase
   end

   always_comb begin
      prev_d  = irq_src;
      // A fresh edge re-arms the bit even if the same source is being accepted now.
      pend_d  = (pend_q & ~(accept_irq ? win_onehot : '0)) | (irq_src & ~prev_q);
      mask_d  = mask_wr ? mask_wdata : mask_q;
      epc_d   = (accept_exc || accept_irq) ? pc_in : epc_q;
      cause_d = cause_q;
      if (accept_exc)                         cause_d = 3'd7;
      else if (accept_irq)                    cause_d = win_cause;
      else if (state_q == SERVICE && eret)    cause_d = 3'd0;
      // An exception that cannot be entered (kernel mode, or already in a handler) is fatal.
      dbl_d   = dbl_q | (exc_req & ((state_q != IDLE) | pchigh));
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         prev_q  <= '0;
         pend_q  <= '0;
         mask_q  <= '0;
         epc_q   <= '0;
         cause_q <= '0;
         dbl_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         prev_q  <= prev_d;
         pend_q  <= pend_d;
         mask_q  <= mask_d;
         epc_q   <= epc_d;
         cause_q <= cause_d;
         dbl_q   <= dbl_d;
      end
   end

   always_comb begin
      irq_out    = (state_q == TAKE_IRQ);
      exc_out    = (state_q == TAKE_EXC);
      in_service = (state_q != IDLE);
      cause      = cause_q;
      epc        = epc_q;
      irq_mask   = mask_q;
      dbl_fault  = dbl_q;
   end

endmodule

// File: tb/tb_irq_arbiter.sv
// Bench for irq_arbiter: directed scenarios followed by random traffic, all outputs
// compared every cycle against a cycle-level behavioural model.
module tb_irq_arbiter;

   localparam int NSRC = 4;

   logic            clk = 1'b0;
   logic            reset;
   logic [NSRC-1:0] irq_src;
   logic            mask_wr;
   logic [NSRC-1:0] mask_wdata;
   logic            pchigh;
   logic            exc_req;
   logic [31:0]     pc_in;
   logic            eret;
   logic            irq_out, exc_out, in_service, dbl_fault;
   logic [2:0]      cause;
   logic [31:0]     epc;
   logic [NSRC-1:0] irq_mask;

   int n_tests = 0;
   int n_fail  = 0;

   irq_arbiter #(.NSRC(NSRC)) dut (
      .clk(clk), .reset(reset), .irq_src(irq_src), .mask_wr(mask_wr),
      .mask_wdata(mask_wdata), .pchigh(pchigh), .exc_req(exc_req), .pc_in(pc_in),
      .eret(eret), .irq_out(irq_out), .exc_out(exc_out), .cause(cause), .epc(epc),
      .irq_mask(irq_mask), .in_service(in_service), .dbl_fault(dbl_fault)
   );

   always #5 clk = ~clk;

   // Reference model: pending/mask as plain bit arrays, handler as an "active" flag
   // plus a one-cycle entry pulse.
   bit          m_prev[NSRC], m_pend[NSRC], m_mask[NSRC];
   bit          m_active, m_irq, m_exc, m_dbl;
   int          m_cause;
   logic [31:0] m_epc;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < NSRC; i++) begin
         m_prev[i] = 0; m_pend[i] = 0; m_mask[i] = 0;
      end
      m_active = 0; m_irq = 0; m_exc = 0; m_dbl = 0; m_cause = 0; m_epc = '0;
   endfunction

   function automatic void model_step();
      int win;
      bit take_exc, in_pulse;
      win      = -1;
      take_exc = 0;
      in_pulse = m_irq || m_exc;
      if (!m_active) begin
         if (exc_req && pchigh) m_dbl = 1;
         if (!pchigh) begin
            if (exc_req) take_exc = 1;
            else
               for (int i = 0; i < NSRC; i++)
                  if (win < 0 && m_pend[i] && m_mask[i]) win = i;
         end
      end else begin
         if (exc_req) m_dbl = 1;
         if (!in_pulse && eret) begin
            m_active = 0;
            m_cause  = 0;
         end
      end
      m_exc = take_exc;
      m_irq = (win >= 0);
      if (take_exc || win >= 0) begin
         m_active = 1;
         m_epc    = pc_in;
         m_cause  = take_exc ? 7 : win + 1;
      end
      for (int i = 0; i < NSRC; i++) begin
         m_pend[i] = (m_pend[i] && i != win) || (irq_src[i] && !m_prev[i]);
         m_prev[i] = irq_src[i];
         if (mask_wr) m_mask[i] = mask_wdata[i];
      end
   endfunction

   task automatic compare_all();
      logic [NSRC-1:0] mvec;
      for (int i = 0; i < NSRC; i++) mvec[i] = m_mask[i];
      check("irq_out",    32'(irq_out),    32'(m_irq));
      check("exc_out",    32'(exc_out),    32'(m_exc));
      check("in_service", 32'(in_service), 32'(m_active));
      check("dbl_fault",  32'(dbl_fault),  32'(m_dbl));
      check("cause",      32'(cause),      32'(m_cause));
      check("epc",        epc,             m_epc);
      check("irq_mask",   32'(irq_mask),   32'(mvec));
   endtask

   // One clock: model follows the edge, outputs checked 1 ns later.
   task automatic cycle();
      @(posedge clk);
      if (!reset) model_reset();
      else        model_step();
      #1;
      compare_all();
   endtask

   task automatic idle_inputs();
      mask_wr = 0; mask_wdata = '0; pchigh = 0; exc_req = 0; eret = 0;
   endtask

   initial begin
      reset = 0; irq_src = '0; pc_in = '0;
      idle_inputs();
      model_reset();
      cycle(); cycle();
      reset = 1;
      cycle();

      // Masked-in source 2: irq_out two edges after its rising edge, one cycle wide.
      mask_wr = 1; mask_wdata = 4'b0101;
      cycle();
      mask_wr = 0; irq_src = 4'b0100; pc_in = 32'h0040_0010;
      cycle();
      check("t1_not_yet", 32'(irq_out), 32'd0);
      cycle();
      check("t1_irq", 32'(irq_out), 32'd1);
      check("t1_cause", 32'(cause), 32'd3);
      check("t1_epc", epc, 32'h0040_0010);
      cycle();
      check("t1_pulse_end", 32'(irq_out), 32'd0);
      check("t1_svc", 32'(in_service), 32'd1);
      cycle();
      eret = 1;
      cycle();
      check("t1_eret", 32'(in_service), 32'd0);
      eret = 0;

      // Two simultaneous edges: index 1 first, index 3 after a gap cycle.
      mask_wr = 1; mask_wdata = 4'b1111; irq_src = '0;
      cycle();
      mask_wr = 0; irq_src = 4'b1010;
      cycle();
      cycle();
      check("t2_first", 32'(cause), 32'd2);
      cycle();
      eret = 1;
      cycle();
      eret = 0;
      check("t2_gap", 32'(irq_out), 32'd0);
      cycle();
      check("t2_second_irq", 32'(irq_out), 32'd1);
      check("t2_second", 32'(cause), 32'd4);
      cycle();
      eret = 1;
      cycle();
      eret = 0;

      // Exception beats a pending interrupt; the interrupt follows after eret.
      irq_src = '0;
      cycle();
      irq_src = 4'b0001;
      cycle();
      exc_req = 1; pc_in = 32'h0040_0100;
      cycle();
      exc_req = 0;
      check("t3_exc", 32'(exc_out), 32'd1);
      check("t3_cause", 32'(cause), 32'd7);
      cycle();
      eret = 1;
      cycle();
      eret = 0;
      cycle();
      check("t3_irq_after", 32'(irq_out), 32'd1);
      check("t3_cause1", 32'(cause), 32'd1);
      cycle();
      eret = 1;
      cycle();
      eret = 0;

      // Kernel mode holds off entry until pchigh drops.
      pchigh = 1; irq_src = '0; mask_wr = 1; mask_wdata = 4'b0001;
      cycle();
      mask_wr = 0; irq_src = 4'b0001;
      cycle();
      for (int i = 0; i < 5; i++) begin
         cycle();
         check("t4_held", 32'(irq_out), 32'd0);
      end
      pchigh = 0;
      cycle();
      check("t4_irq", 32'(irq_out), 32'd1);
      check("t4_cause", 32'(cause), 32'd1);

      // Exception during service: sticky double fault, no exc_out.
      cycle();
      exc_req = 1;
      cycle();
      exc_req = 0;
      check("t5_dbl", 32'(dbl_fault), 32'd1);
      check("t5_no_exc", 32'(exc_out), 32'd0);
      eret = 1;
      cycle();
      eret = 0;
      cycle();
      check("t5_dbl_sticky", 32'(dbl_fault), 32'd1);

      // Masked pending source taken once unmasked.
      irq_src = '0; mask_wr = 1; mask_wdata = 4'b0000;
      cycle();
      mask_wr = 0; irq_src = 4'b0010;
      for (int i = 0; i < 10; i++) begin
         cycle();
         check("t6_masked", 32'(irq_out), 32'd0);
      end
      mask_wr = 1; mask_wdata = 4'b0010;
      cycle();
      mask_wr = 0;
      check("t6_wait", 32'(irq_out), 32'd0);
      cycle();
      check("t6_irq", 32'(irq_out), 32'd1);
      check("t6_cause", 32'(cause), 32'd2);

      // Asynchronous reset in the middle of service.
      cycle();
      #3 reset = 0;
      #1;
      check("t7_svc", 32'(in_service), 32'd0);
      check("t7_cause", 32'(cause), 32'd0);
      check("t7_epc", epc, 32'd0);
      check("t7_dbl", 32'(dbl_fault), 32'd0);
      check("t7_mask", 32'(irq_mask), 32'd0);
      model_reset();
      cycle();
      reset = 1;
      cycle();

      // Random traffic.
      for (int n = 0; n < 2000; n++) begin
         for (int i = 0; i < NSRC; i++)
            if ($urandom_range(7) == 0) irq_src[i] = ~irq_src[i];
         mask_wr    = ($urandom_range(15) == 0);
         mask_wdata = NSRC'($urandom);
         pchigh     = ($urandom_range(3) == 0);
         exc_req    = ($urandom_range(29) == 0);
         eret       = ($urandom_range(3) == 0);
         pc_in      = $urandom;
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/irq_arbiter.md
# irq_arbiter

Sequential interrupt/exception arbiter that drives the `Interrupt` and `Exception` inputs of the CPU control decoder. It latches requests from the peripheral interrupt lines and applies a software mask. It selects one event by fixed priority, suppresses entry while the CPU runs in kernel mode (`pchigh`=1) or a handler is in service, and records cause and EPC for the handler. It sits between the peripheral bus (timer, UART, keys) and the single-cycle MIPS control path.

## Interface
- `NSRC`, 4: number of peripheral interrupt lines; index 0 has highest priority.
- `clk`  in  1  system clock, rising-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `irq_src`  in  NSRC  level request lines from peripherals.
- `mask_wr`  in  1  one-cycle write strobe for mask register.
- `mask_wdata`  in  NSRC  new mask value; 1 = source enabled.
- `pchigh`  in  1  PC[31] of the current instruction; 1 = kernel mode.
- `exc_req`  in  1  undefined-instruction/exception request for the current instruction.
- `pc_in`  in  32  PC of the current instruction.
- `eret`  in  1  one-cycle pulse when the handler returns.
- `irq_out`  out  1  to control decoder `Interrupt`.
- `exc_out`  out  1  to control decoder `Exception`.
- `cause`  out  3  0 = none, 1..NSRC = source index+1, 7 = exception.
- `epc`  out  32  PC captured at acceptance.
- `irq_mask`  out  NSRC  current mask register.
- `in_service`  out  1  high while a handler is active.
- `dbl_fault`  out  1  sticky; exception arrived while it could not be taken.

## Operation
- Reset (`reset`=0, async): state IDLE. All outputs 0. Pending, edge history, mask, `epc` and `cause` are 0.
- Edge capture: `prev` <= `irq_src` each cycle. `pend[i]` is set on a rising edge of `irq_src[i]`. It is cleared when source i is accepted. If a set and a clear hit the same cycle, set wins.
- Mask: on `mask_wr`, `irq_mask` <= `mask_wdata`, visible next cycle. Masked sources still latch pending and are taken once unmasked.
- Eligible interrupt: `pend & irq_mask` nonzero, with the lowest set index winning.
- States:
  - IDLE
    - `exc_req`=1 and `pchigh`=0 → TAKE_EXC. The exception beats any interrupt.
    - Else an eligible interrupt exists and `pchigh`=0 → TAKE_IRQ.
    - `exc_req`=1 with `pchigh`=1 → stay IDLE and set `dbl_fault`.
  - TAKE_EXC / TAKE_IRQ
    - Each lasts exactly one cycle: `exc_out`/`irq_out`=1 and `in_service`=1.
    - Then → SERVICE.
  - SERVICE
    - `in_service`=1 and `irq_out`=`exc_out`=0.
    - `eret` → IDLE.
    - `exc_req` here sets `dbl_fault`; the request is otherwise dropped.
- At the acceptance edge (IDLE → TAKE_*):
  - `epc` <= `pc_in`.
  - `cause` <= 7 for an exception, or winning index+1 for an interrupt.
  - The winning `pend` bit clears.
- `epc` and `cause` hold until the next acceptance. `cause` returns to 0 on `eret`.
- `eret` outside SERVICE: ignored.
- `dbl_fault` clears only on reset.

## Timing
- All outputs are registered; there is no combinational input→output path.
- Latency from the `irq_src` rising edge to `irq_out`=1:
  - Edge sampled at edge k.
  - Pending visible after edge k.
  - Acceptance at edge k+1.
  - `irq_out` high from edge k+1 for one cycle.
  - Total: 2 cycles, provided the source is unmasked, state is IDLE and `pchigh`=0.
- Latency from `exc_req` (sampled in IDLE) to `exc_out`: 1 cycle, one-cycle pulse.
- After `eret`, the state is IDLE the following cycle. A new acceptance can occur at the next edge, so there is a minimum 1 idle cycle between services.
- `pchigh` is sampled only in IDLE at the acceptance decision. Requests while `pchigh`=1 stay pending (interrupts) or set `dbl_fault` (exceptions).
- Reset asserted mid-service: state returns to IDLE immediately, and all pending requests are lost.

## Test plan
- Reset, then `mask_wr` with 4'b0101. Raise `irq_src[2]` with `pc_in`=0x00400010 and `pchigh`=0. Required: `irq_out` is 1 for exactly one cycle, 2 cycles after the edge; `cause`=3; `epc`=0x00400010; `in_service` stays 1 until `eret`.
- Mask 4'b1111. Raise `irq_src[3]` and `irq_src[1]` in the same cycle. Required: first service has `cause`=2. After `eret`, the next service follows with `cause`=4, at least 1 idle cycle later.
- `exc_req`=1 in the same cycle an eligible interrupt is pending. Required: `exc_out` pulses and `cause`=7. After `eret`, the interrupt is taken.
- `pchigh`=1 while `irq_src[0]` rises with mask 1. Required: no `irq_out`. When `pchigh` drops to 0, `irq_out` fires the next cycle with `cause`=1.
- During SERVICE, pulse `exc_req`. Required: `dbl_fault`=1 and no `exc_out`. `dbl_fault` stays 1 after `eret` and clears only on reset.
- Masked pending then unmask: with mask 0, raise `irq_src[1]`. Required: no `irq_out` for 10 cycles. Write mask 4'b0010: `irq_out` asserts 1 cycle after the write takes effect.
- Async reset low mid-SERVICE. Required: all outputs are 0 immediately, without waiting for a clock edge.
